// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and receiver:
//   DATA_BITS      - payload bits per frame
//   LINE_IDLE      - level of an idle serial line
//   tx_state_e     - transmitter state encoding
//   clks_per_bit() - clocks per bit (truncating FCLK/BAUD)
//   cnt_width()    - counter width able to hold 0..n-1
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam logic        LINE_IDLE = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Truncating division: 50 MHz / 115200 baud gives 434.
    function automatic int unsigned clks_per_bit(input int unsigned fclk,
                                                 input int unsigned baud);
        return fclk / baud;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// ---------------------------------------------------------------------------
// uart_baud_cnt
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 and returns to 0 by itself at
// the terminal count; i_clear forces it back to 0 (used on state entry).
// Ports:
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   i_clear       in   restart the bit period on the next edge
//   o_bit_done_c  out  combinational, high during the last clock of a bit
// ---------------------------------------------------------------------------
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_bit_done_c
);

    localparam int unsigned CNT_W = cnt_width(CLKS_PER_BIT);

    logic [CNT_W-1:0] r_count;
    logic             w_done;

    assign w_done       = (r_count == CNT_W'(CLKS_PER_BIT - 1));
    assign o_bit_done_c = w_done;

    // Bit-period counter; never runs past the terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear || w_done) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// UART transmitter: serialises bytes into 8N1 frames (LSB first) with a
// one-entry holding register so frames can run back-to-back with no idle gap.
// Optional build macro UART_TX_PARITY_EN adds a parity bit (8E1/8O1) and the
// PARITY_ODD parameter (0 = even, 1 = odd).
// Ports:
//   clk50m    in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   tx_data   in   byte to send, sampled on accept
//   tx_valid  in   source has a byte
//   tx_ready  out  holding register empty (accept = tx_valid && tx_ready)
//   tx        out  serial line, idle high, registered
//   tx_idle   out  no frame in progress and holding register empty
// ---------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned FCLK       = 50_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned STOP_BITS  = 1
`ifdef UART_TX_PARITY_EN
    ,
    parameter bit          PARITY_ODD = 1'b0
`endif
) (
    input  logic       clk50m,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_idle
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(FCLK, BAUD);
    // Index of the final data bit and of the final stop bit (1 or 2 stops).
    localparam logic [2:0]  DATA_LAST    = 3'(DATA_BITS - 1);
    localparam logic [2:0]  STOP_LAST    = (STOP_BITS == 2) ? 3'd1 : 3'd0;

    tx_state_e  r_state;
    tx_state_e  w_next_state;

    logic [7:0] r_hold;
    logic       r_hold_full;
    logic [7:0] r_shift;
    logic [2:0] r_bit_idx;
    logic       r_tx;
    logic       r_ready;
    logic       r_idle;
`ifdef UART_TX_PARITY_EN
    logic       r_parity;
`endif

    logic       w_accept;
    logic       w_load;
    logic       w_bit_done;
    logic       w_clear;
    logic       w_hold_full_next;
    logic [7:0] w_shift_next;
    logic       w_tx_next;

    assign w_accept = tx_valid && !r_hold_full;

    // Bit timer restarts on every state entry and stays parked while idle.
    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk          (clk50m),
        .rst_n        (rst_n),
        .i_clear      (w_clear),
        .o_bit_done_c (w_bit_done)
    );

    // State register.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; w_load moves the holding register into the shifter.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_hold_full) begin
                    w_next_state = START;
                    w_load       = 1'b1;
                end
            end
            START: begin
                if (w_bit_done) begin
                    w_next_state = DATA;
                end
            end
            DATA: begin
                if (w_bit_done && (r_bit_idx == DATA_LAST)) begin
`ifdef UART_TX_PARITY_EN
                    w_next_state = PARITY;
`else
                    w_next_state = STOP;
`endif
                end
            end
            PARITY: begin
                if (w_bit_done) begin
                    w_next_state = STOP;
                end
            end
            STOP: begin
                // A queued byte goes straight to START: zero idle cycles.
                if (w_bit_done && (r_bit_idx == STOP_LAST)) begin
                    if (r_hold_full) begin
                        w_next_state = START;
                        w_load       = 1'b1;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign w_clear = (w_next_state != r_state) || (r_state == IDLE);

    // Accept and load are mutually exclusive: accept needs empty, load full.
    assign w_hold_full_next = w_accept ? 1'b1 :
                              w_load   ? 1'b0 : r_hold_full;

    always_comb begin
        w_shift_next = r_shift;
        if (w_load) begin
            w_shift_next = r_hold;
        end else if ((r_state == DATA) && w_bit_done) begin
            w_shift_next = {1'b0, r_shift[7:1]};
        end
    end

    // Line level follows the state being entered so tx is a plain flop.
    always_comb begin
        w_tx_next = LINE_IDLE;
        case (w_next_state)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  w_tx_next = r_parity;
`endif
            default: w_tx_next = LINE_IDLE;
        endcase
    end

    // Holding register and handshake.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_ready     <= 1'b1;
        end else begin
            if (w_accept) begin
                r_hold <= tx_data;
            end
            r_hold_full <= w_hold_full_next;
            r_ready     <= !w_hold_full_next;
        end
    end

    // Shifter, bit index and registered line outputs.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_tx      <= LINE_IDLE;
            r_idle    <= 1'b1;
        end else begin
            r_shift <= w_shift_next;
            if (w_clear) begin
                r_bit_idx <= '0;
            end else if (w_bit_done && ((r_state == DATA) || (r_state == STOP))) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            r_tx   <= w_tx_next;
            r_idle <= (w_next_state == IDLE) && !w_hold_full_next;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity is fixed when the byte enters the shifter.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= (^r_hold) ^ PARITY_ODD;
        end
    end
`endif

    assign tx       = r_tx;
    assign tx_ready = r_ready;
    assign tx_idle  = r_idle;

endmodule
